demux2_buf: RTL
===============

Name: demux2_buf

Overview:
- Buffered 1-to-2 router: one 32-bit producer stream steered by a select bit to one of two consumer channels (A for sel=0, B for sel=1).
- Each channel has its own DEPTH-entry FIFO and a valid/ready handshake.
- Sits between a result source (ALU/load path) and two downstream sinks, e.g. a writeback sink and a store/forward sink.
- Complements the combinational 2:1 select on the merge side of the datapath.

Parameters:
- WIDTH, 32, data width of input and both output channels.
- DEPTH, 2, entries per channel FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  router can accept the word for the currently selected channel.
- in_sel  input  1  destination: 0 routes to A, 1 routes to B.
- in_data  input  WIDTH  word to route.
- a_valid  output  1  channel A FIFO non-empty.
- a_ready  input  1  channel A consumer accepts.
- a_data  output  WIDTH  channel A head entry.
- b_valid  output  1  channel B FIFO non-empty.
- b_ready  input  1  channel B consumer accepts.
- b_data  output  WIDTH  channel B head entry.
- a_count  output  $clog2(DEPTH)+1  occupancy of channel A, range 0..DEPTH.
- b_count  output  $clog2(DEPTH)+1  occupancy of channel B, range 0..DEPTH.

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high at a clk rising edge takes effect at that edge.
- Reset values:
  - all pointers = 0, both counts = 0;
  - a_valid = b_valid = 0;
  - all storage entries = 0, so a_data = b_data = 0.
- in_ready is combinational:
  - !a_full when in_sel=0; !b_full when in_sel=1;
  - does not depend on in_valid;
  - forced 0 while rst=1.
- Push:
  - in_valid && in_ready at an edge writes in_data to the selected FIFO tail;
  - the tail pointer increments modulo DEPTH;
  - the non-selected channel is untouched.
- Pop:
  - x_valid && x_ready at an edge advances that head pointer modulo DEPTH;
  - the two channels pop independently, in the same cycle if both handshake.
- Latency:
  - a word pushed at edge N is visible on x_valid/x_data after edge N;
  - minimum 1 cycle; no combinational in→out bypass.
- x_valid = (x_count != 0).
- x_data = storage[head], driven directly from the registered array, stable while x_valid && !x_ready.
- Count update per edge:
  - +1 on push only, -1 on pop only;
  - unchanged on simultaneous push and pop to the same channel (allowed only when not full, since in_ready=0 when full).
- Full (count=DEPTH):
  - in_ready=0 for that select; a pop in the same cycle does not raise in_ready (no pass-through);
  - producer stalls, with in_valid/in_sel/in_data held.
- Empty (count=0):
  - x_valid=0; x_ready is ignored; no pointer movement.
- Ordering:
  - strict FIFO per channel;
  - no ordering guarantee between channels.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from count, not pointer compare.
- in_sel change while in_valid && !in_ready: permitted. in_ready re-evaluates combinationally against the newly selected channel.
- Reset mid-operation: all buffered entries are discarded, counts go to 0, and the valids drop at the reset edge.
- in_valid=0: no state change on the input side regardless of in_sel/in_data.

Test Plan:
- Reset then idle:
  - assert rst for 2 cycles with in_valid=1, in_sel=0, in_data=0x11111111 → in_ready=0 during reset;
  - after release a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=0.
- Route and latency:
  - push 0xDEADBEEF (sel=0) at edge N → a_valid=1, a_data=0xDEADBEEF after edge N, a_count=1;
  - b_valid stays 0.
- Fill and stall:
  - with DEPTH=2, a_ready=0, push 0x1 and 0x2 to A → a_count=2, in_ready=0 for sel=0;
  - switch in_sel=1 → in_ready=1 and push 0x3 lands in B with b_count=1.
- Full with same-cycle pop:
  - A full with a_ready=1 and in_sel=0 → in_ready stays 0 that cycle;
  - next cycle a_count=1, in_ready=1, and a_data=0x2.
- Wrap and order:
  - stream 0x10..0x17 into B with b_ready toggling 1,0,1,0 → output order 0x10..0x17 exactly;
  - pointers wrap 4 times; b_count never exceeds 2;
  - simultaneous push/pop keeps b_count constant.
- Reset mid-stream:
  - A holds 2 entries and B holds 1; assert rst one cycle → all valids 0 and counts 0 next cycle;
  - new push 0xCAFE0001 to A emerges as the first A word.

Source files
------------

// File: rtl/demux2_buf.sv
// Buffered 1-to-2 router: one valid/ready input stream is steered by in_sel
// into one of two independent DEPTH-entry FIFOs (A for sel=0, B for sel=1).
module demux2_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [WIDTH-1:0]         a_data,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [WIDTH-1:0]         b_data,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);
  localparam int NUM_CH = 2;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;

  logic [NUM_CH-1:0]            ch_push, ch_rdy, ch_vld, ch_full;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0][CW-1:0]    ch_cnt;

  // Full is judged before any same-cycle pop, so a full channel never passes through.
  assign in_ready = !rst && !ch_full[in_sel];

  assign ch_rdy  = {b_ready, a_ready};
  assign a_valid = ch_vld[0];
  assign b_valid = ch_vld[1];
  assign a_data  = ch_data[0];
  assign b_data  = ch_data[1];
  assign a_count = ch_cnt[0];
  assign b_count = ch_cnt[1];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic [CW-1:0]               cnt;
    logic                        pop;

    assign ch_push[g] = in_valid && in_ready && (in_sel == 1'(g));
    assign pop        = (cnt != '0) && ch_rdy[g];
    assign ch_full[g] = (cnt == CW'(DEPTH));
    assign ch_vld[g]  = (cnt != '0);
    assign ch_data[g] = mem[rd_ptr];
    assign ch_cnt[g]  = cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        mem    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (ch_push[g]) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({ch_push[g], pop})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule
